// File: rtl/lut_sweep_pkg.sv
// Shared types and derived-size helpers for the LUT table sweeper.
package lut_sweep_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSweep,
      StEmit,
      StDone
   } sweep_state_e;

   // Number of table entries for a neuron with in_bits inputs.
   function automatic int unsigned calc_entries(input int unsigned in_bits);
      return 32'd1 << in_bits;
   endfunction

   // Entries packed into one output word.
   function automatic int unsigned calc_epw(input int unsigned word_w,
                                            input int unsigned out_bits);
      return word_w / out_bits;
   endfunction

   // Output words needed to carry the whole table.
   function automatic int unsigned calc_num_words(input int unsigned in_bits,
                                                  input int unsigned out_bits,
                                                  input int unsigned word_w);
      return (calc_entries(in_bits) * out_bits) / word_w;
   endfunction

   // True when words hold a whole number of entries and the table a whole number of words.
   function automatic bit widths_ok(input int unsigned in_bits,
                                    input int unsigned out_bits,
                                    input int unsigned word_w);
      if (out_bits == 0 || word_w == 0) return 1'b0;
      if ((word_w % out_bits) != 0) return 1'b0;
      if (((calc_entries(in_bits) * out_bits) % word_w) != 0) return 1'b0;
      return 1'b1;
   endfunction

endpackage

// File: rtl/lut_sweep_packer.sv
// Word assembly register: clears to zero and accepts one OUT_BITS slot write per cycle.
module lut_sweep_packer
   import lut_sweep_pkg::*;
#(
   parameter int unsigned OUT_BITS = 1,
   parameter int unsigned WORD_W   = 32,
   parameter int unsigned SLOT_W   = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                wr,
   input  logic [SLOT_W-1:0]   slot,
   input  logic [OUT_BITS-1:0] wdata,
   output logic [WORD_W-1:0]   word
);

   localparam int unsigned EPW = calc_epw(WORD_W, OUT_BITS);

   logic [WORD_W-1:0] word_q, word_d;

   // Next word: clear wins over a slot write; slot 0 lands in the LSBs.
   always_comb begin
      word_d = word_q;
      if (clr) begin
         word_d = '0;
      end else if (wr) begin
         for (int unsigned s = 0; s < EPW; s++) begin
            if (slot == SLOT_W'(s)) begin
               word_d[s*OUT_BITS +: OUT_BITS] = wdata;
            end
         end
      end
   end

   // Word register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= '0;
      end else begin
         word_q <= word_d;
      end
   end

   assign word = word_q;

endmodule

// File: rtl/lut_table_sweeper.sv
// Drives a LUT neuron through every input code, captures its responses and streams the
// packed truth table out over valid/ready, lowest code first.
module lut_table_sweeper
   import lut_sweep_pkg::*;
#(
   parameter int unsigned IN_BITS  = 8,
   parameter int unsigned OUT_BITS = 1,
   parameter int unsigned WORD_W   = 32,
   parameter int unsigned LAT      = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic [IN_BITS-1:0]  lut_in,
   input  logic [OUT_BITS-1:0] lut_out,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [WORD_W-1:0]   m_data,
   output logic                m_last
);

   localparam int unsigned ENTRIES   = calc_entries(IN_BITS);
   localparam int unsigned EPW       = calc_epw(WORD_W, OUT_BITS);
   localparam int unsigned NUM_WORDS = calc_num_words(IN_BITS, OUT_BITS, WORD_W);
   localparam int unsigned SLOT_W    = (EPW > 1) ? $clog2(EPW) : 1;
   localparam int unsigned WAIT_W    = (LAT > 0) ? $clog2(LAT + 1) : 1;

   if (!widths_ok(IN_BITS, OUT_BITS, WORD_W) || NUM_WORDS == 0) begin : g_bad_widths
      $error("lut_table_sweeper: WORD_W must be a multiple of OUT_BITS and divide the table");
   end

   sweep_state_e        state_q, state_d;
   logic [IN_BITS-1:0]  idx_q, idx_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [SLOT_W-1:0]   slot;
   logic                slot_last;
   logic                idx_last;
   logic                sample;
   logic                pack_clr;
   logic                pack_wr;
   logic [WORD_W-1:0]   pack_word;

   // EPW is a power of two whenever the width check holds, so idx mod EPW is its low bits.
   if (EPW > 1) begin : g_slot
      assign slot = idx_q[SLOT_W-1:0];
   end else begin : g_slot_one
      assign slot = '0;
   end

   assign slot_last = (slot == SLOT_W'(EPW - 1));
   assign idx_last  = (idx_q == IN_BITS'(ENTRIES - 1));
   assign sample    = (wait_q == WAIT_W'(LAT));

   // Sequencing: walk codes, settle LAT cycles per code, emit each word as it fills.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      wait_d   = wait_q;
      pack_clr = 1'b0;
      pack_wr  = 1'b0;
      case (state_q)
         StIdle: begin
            idx_d    = '0;
            wait_d   = '0;
            pack_clr = 1'b1;
            if (start) begin
               state_d = StSweep;
            end
         end
         StSweep: begin
            if (sample) begin
               pack_wr = 1'b1;
               wait_d  = '0;
               if (slot_last) begin
                  state_d = StEmit;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         StEmit: begin
            if (m_ready) begin
               if (idx_last) begin
                  state_d = StDone;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = StSweep;
               end
            end
         end
         StDone: begin
            idx_d   = '0;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State, code index and settle counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         wait_q  <= wait_d;
      end
   end

   lut_sweep_packer #(
      .OUT_BITS (OUT_BITS),
      .WORD_W   (WORD_W),
      .SLOT_W   (SLOT_W)
   ) u_packer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (pack_clr),
      .wr    (pack_wr),
      .slot  (slot),
      .wdata (lut_out),
      .word  (pack_word)
   );

   // Outputs decode straight from the state register so reset clears them asynchronously.
   always_comb begin
      busy    = (state_q == StSweep) || (state_q == StEmit);
      done    = (state_q == StDone);
      m_valid = (state_q == StEmit);
      m_last  = (state_q == StEmit) && idx_last;
      m_data  = (state_q == StEmit) ? pack_word : '0;
   end

   // The code register doubles as the neuron drive; it holds through EMIT.
   assign lut_in = idx_q;

endmodule
